dmem_seq: RTL

//  Address/control sequencer placed directly upstream of the DMem data memory. Accepts one

---
 rtl/dmem_seq_pkg.sv | 35 +++
 rtl/dmem_agu.sv | 36 +++
 rtl/dmem_seq.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/dmem_seq_pkg.sv
// Shared constants for the DMem address sequencer: select codes, FSM encodings,
// default widths and the latched transfer-control payload.
package dmem_seq_pkg;

  localparam int unsigned ADDR_DMEM    = 10;
  localparam int unsigned ADDR_W_DEF   = ADDR_DMEM;
  localparam int unsigned LEN_W_DEF    = 11;
  localparam int unsigned STRIDE_W_DEF = 4;
  localparam int unsigned SEL_W        = 2;
  localparam int unsigned STATE_W      = 2;

  localparam logic [SEL_W-1:0] SEL_OFF = 2'b00;
  localparam logic [SEL_W-1:0] SEL_V   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_H   = 2'b11;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  typedef logic [SEL_W-1:0] sel_t;

  // Control fields held for the lifetime of one transfer.
  typedef struct packed {
    logic rd_en;
    logic wr_en;
    sel_t sel_i;
    sel_t sel_o;
  } xfer_ctl_t;

  // Only the V and H port codes name a real DMem port; anything else disables that side.
  function automatic logic sel_active(input sel_t sel);
    return (sel == SEL_V) || (sel == SEL_H);
  endfunction

endpackage

// File: rtl/dmem_agu.sv
// Strided address generator: loads a base and stride, then steps by the stride on
// each advance, wrapping silently at the DMem depth.
module dmem_agu
  import dmem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned STRIDE_W = STRIDE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic                advance,
  input  logic [ADDR_W-1:0]   base,
  input  logic [STRIDE_W-1:0] stride,
  output logic [ADDR_W-1:0]   addr
);

  logic [STRIDE_W-1:0] stride_q;
  logic [ADDR_W-1:0]   addr_step;

  assign addr_step = addr + ADDR_W'(stride_q);

  // Load wins over advance; a loaded stride is used from the next element on.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr     <= '0;
      stride_q <= '0;
    end else if (load) begin
      addr     <= base;
      stride_q <= stride;
    end else if (advance) begin
      addr     <= addr_step;
    end
  end

endmodule

// File: rtl/dmem_seq.sv
// DMem address/control sequencer: accepts one strided transfer command and streams
// read/write addresses, write enable and port selects one element per cycle.
module dmem_seq
  import dmem_seq_pkg::*;
#(
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned LEN_W    = LEN_W_DEF,
  parameter int unsigned STRIDE_W = STRIDE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [ADDR_W-1:0]   cmd_rbase,
  input  logic [ADDR_W-1:0]   cmd_wbase,
  input  logic [STRIDE_W-1:0] cmd_rstride,
  input  logic [STRIDE_W-1:0] cmd_wstride,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic                cmd_rd_en,
  input  logic                cmd_wr_en,
  input  logic [1:0]          cmd_sel_i,
  input  logic [1:0]          cmd_sel_o,
  input  logic                stall,
  input  logic                abort,
  output logic [ADDR_W-1:0]   r_addr,
  output logic [ADDR_W-1:0]   w_addr,
  output logic                we_ram,
  output logic [1:0]          sel_ram_i,
  output logic [1:0]          sel_ram_o,
  output logic                rd_vld,
  output logic                busy,
  output logic                done,
  output logic                aborted
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt;
  xfer_ctl_t          ctl_q;
  logic               aborted_q;
  logic               accept;
  logic               issue;
  logic               last_elem;
  logic               in_run;

  assign in_run    = (state == ST_RUN);
  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign issue     = in_run && !stall && !abort;
  assign last_elem = (cnt == (len_q - LEN_W'(1)));

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; abort has priority over stall and over the last element.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_nxt = (cmd_len == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_nxt = ST_DONE;
        end else if (issue && last_elem) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Command latch and element counter; a disabled port code forces its side off.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_q     <= '0;
      cnt       <= '0;
      ctl_q     <= '0;
      aborted_q <= 1'b0;
    end else begin
      if (accept) begin
        len_q       <= cmd_len;
        cnt         <= '0;
        ctl_q.rd_en <= cmd_rd_en && sel_active(cmd_sel_o);
        ctl_q.wr_en <= cmd_wr_en && sel_active(cmd_sel_i);
        ctl_q.sel_i <= cmd_sel_i;
        ctl_q.sel_o <= cmd_sel_o;
        aborted_q   <= 1'b0;
      end else if (issue) begin
        cnt <= cnt + LEN_W'(1);
      end
      if (in_run && abort) begin
        aborted_q <= 1'b1;
      end else if (state == ST_DONE) begin
        aborted_q <= 1'b0;
      end
    end
  end

  dmem_agu #(
    .ADDR_W  (ADDR_W),
    .STRIDE_W(STRIDE_W)
  ) u_ragu (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .advance(issue),
    .base   (cmd_rbase),
    .stride (cmd_rstride),
    .addr   (r_addr)
  );

  dmem_agu #(
    .ADDR_W  (ADDR_W),
    .STRIDE_W(STRIDE_W)
  ) u_wagu (
    .clk    (clk),
    .rst    (rst),
    .load   (accept),
    .advance(issue),
    .base   (cmd_wbase),
    .stride (cmd_wstride),
    .addr   (w_addr)
  );

  // Output decode from state so that an async reset drops every strobe at once.
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    we_ram    = 1'b0;
    rd_vld    = 1'b0;
    sel_ram_i = SEL_OFF;
    sel_ram_o = SEL_OFF;
    case (state)
      ST_IDLE: cmd_ready = 1'b1;
      ST_RUN: begin
        busy   = 1'b1;
        we_ram = issue && ctl_q.wr_en;
        rd_vld = issue && ctl_q.rd_en;
        if (ctl_q.wr_en) sel_ram_i = ctl_q.sel_i;
        if (ctl_q.rd_en) sel_ram_o = ctl_q.sel_o;
      end
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign aborted = aborted_q;

endmodule
